// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes and hazard FSM state encodings
package hazard_pkg;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef enum logic {ST_RUN = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// fwd_select: forwarding select for one source operand, EX/MEM over MEM/WB
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_mem_rd,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_wb_rd,
  input  logic          i_wb_we,
  output logic [1:0]    o_sel
);
  logic w_mem_hit, w_wb_hit;
  assign w_mem_hit = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_rs);
  assign o_sel = w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: forwarding, load-use stall, branch flush, multi-cycle freeze and perf counters
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [NSRC*AW-1:0]   ex_rs,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_reg_write_en,
  input  logic                 ex_mem_read,
  input  logic                 ex_mc_start,
  input  logic                 branch_taken,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_reg_write_en,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_reg_write_en,
  output logic [2*NSRC-1:0]    forward_sel,
  output logic                 pc_hold,
  output logic                 ifid_hold,
  output logic                 idex_hold,
  output logic                 idex_bubble,
  output logic                 exmem_bubble,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 mc_done,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  localparam int MCW = $clog2(MC_LAT);
  state_t r_state, w_state_nx;
  logic [MCW-1:0] r_mc_cnt, w_mc_cnt_nx;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [2*NSRC-1:0] w_fwd;
  logic [NSRC-1:0] w_lu_hit;
  logic w_run, w_busy, w_mc_stall, w_lu_stall, w_flush, w_hold;
  genvar k;
  generate
    for (k = 0; k < NSRC; k++) begin : g_src
      fwd_select #(.AW(AW)) u_fwd (
        .i_rs     (ex_rs[k*AW +: AW]),
        .i_mem_rd (mem_rd),
        .i_mem_we (mem_reg_write_en),
        .i_wb_rd  (wb_rd),
        .i_wb_we  (wb_reg_write_en),
        .o_sel    (w_fwd[2*k +: 2])
      );
      assign w_lu_hit[k] = id_rs_used[k] && (id_rs[k*AW +: AW] == ex_rd);
    end
  endgenerate
  assign w_run  = (r_state == ST_RUN);
  assign w_busy = (r_state == ST_BUSY);
  assign w_mc_stall = (w_run && ex_mc_start) || (w_busy && r_mc_cnt != '0);
  // a starting multi-cycle op already freezes the front end, so no extra bubble
  assign w_lu_stall = w_run && !branch_taken && !ex_mc_start && ex_mem_read && (ex_rd != '0) && |w_lu_hit;
  assign w_flush = w_run && branch_taken;
  assign w_hold  = !rst && (w_mc_stall || w_lu_stall);
  assign forward_sel  = rst ? '0 : w_fwd;
  assign pc_hold      = w_hold;
  assign ifid_hold    = w_hold;
  assign idex_hold    = !rst && w_mc_stall;
  assign exmem_bubble = !rst && w_mc_stall;
  assign idex_bubble  = !rst && w_lu_stall;
  assign ifid_flush   = !rst && w_flush;
  assign idex_flush   = !rst && w_flush;
  assign mc_done      = !rst && w_busy && (r_mc_cnt == '0);
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;
  always_comb begin
    w_state_nx  = r_state;
    w_mc_cnt_nx = r_mc_cnt;
    if (w_run && ex_mc_start) begin
      w_state_nx  = ST_BUSY;
      w_mc_cnt_nx = MCW'(MC_LAT - 2);
    end else if (w_busy) begin
      w_state_nx  = (r_mc_cnt == '0) ? ST_RUN : ST_BUSY;
      w_mc_cnt_nx = (r_mc_cnt == '0) ? r_mc_cnt : r_mc_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_mc_cnt <= w_mc_cnt_nx;
      if (pc_hold && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (ifid_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scoreboard bench for a default instance and an NSRC=3/CNT_W=4/MC_LAT=2 instance
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] a_id_rs, a_ex_rs;
  logic [1:0] a_id_used;
  logic [4:0] a_ex_rd, a_mem_rd, a_wb_rd;
  logic a_ex_we, a_ex_mr, a_mc, a_br, a_mem_we, a_wb_we;
  logic [3:0] a_fs;
  logic a_ph, a_ih, a_xh, a_xb, a_eb, a_iff, a_xf, a_md;
  logic [31:0] a_sc, a_fc;

  logic [14:0] b_id_rs, b_ex_rs;
  logic [2:0] b_id_used;
  logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
  logic b_ex_we, b_ex_mr, b_mc, b_br, b_mem_we, b_wb_we;
  logic [5:0] b_fs;
  logic b_ph, b_ih, b_xh, b_xb, b_eb, b_iff, b_xf, b_md;
  logic [3:0] b_sc, b_fc;

  hazard_control_unit dut_a (
    .clk(clk), .rst(rst), .id_rs(a_id_rs), .id_rs_used(a_id_used), .ex_rs(a_ex_rs),
    .ex_rd(a_ex_rd), .ex_reg_write_en(a_ex_we), .ex_mem_read(a_ex_mr), .ex_mc_start(a_mc),
    .branch_taken(a_br), .mem_rd(a_mem_rd), .mem_reg_write_en(a_mem_we), .wb_rd(a_wb_rd),
    .wb_reg_write_en(a_wb_we), .forward_sel(a_fs), .pc_hold(a_ph), .ifid_hold(a_ih),
    .idex_hold(a_xh), .idex_bubble(a_xb), .exmem_bubble(a_eb), .ifid_flush(a_iff),
    .idex_flush(a_xf), .mc_done(a_md), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_control_unit #(.NSRC(3), .MC_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(b_id_rs), .id_rs_used(b_id_used), .ex_rs(b_ex_rs),
    .ex_rd(b_ex_rd), .ex_reg_write_en(b_ex_we), .ex_mem_read(b_ex_mr), .ex_mc_start(b_mc),
    .branch_taken(b_br), .mem_rd(b_mem_rd), .mem_reg_write_en(b_mem_we), .wb_rd(b_wb_rd),
    .wb_reg_write_en(b_wb_we), .forward_sel(b_fs), .pc_hold(b_ph), .ifid_hold(b_ih),
    .idex_hold(b_xh), .idex_bubble(b_xb), .exmem_bubble(b_eb), .ifid_flush(b_iff),
    .idex_flush(b_xf), .mc_done(b_md), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] STALL = 8'b1101_0000;
  localparam logic [7:0] HOLD  = 8'b1110_1000;
  localparam logic [7:0] FLUSH = 8'b0000_0110;
  localparam logic [7:0] DONE  = 8'b0000_0001;

  int checks = 0;
  int failures = 0;
  int e_sc_a = 0, e_fc_a = 0, e_sc_b = 0, e_fc_b = 0;
  logic [77:0] exp_q[$];
  bit dut_q[$];
  string name_q[$];
  logic [77:0] m_exp, m_obs;
  bit m_dut;
  string m_name;

  function automatic logic [77:0] obs(input bit b);
    return b ? {b_fs, b_ph, b_ih, b_xh, b_xb, b_eb, b_iff, b_xf, b_md, 28'd0, b_sc, 28'd0, b_fc}
             : {2'b00, a_fs, a_ph, a_ih, a_xh, a_xb, a_eb, a_iff, a_xf, a_md, a_sc, a_fc};
  endfunction

  // one stimulus cycle: queue the expected response, advance the small counter model
  task automatic cyc(input bit b, input string nm, input logic [5:0] fs, input logic [7:0] ctl);
    int sc, fc;
    sc = b ? e_sc_b : e_sc_a;
    fc = b ? e_fc_b : e_fc_a;
    exp_q.push_back({fs, ctl, 32'(sc), 32'(fc)});
    dut_q.push_back(b);
    name_q.push_back(nm);
    if (rst) begin
      e_sc_a = 0; e_fc_a = 0; e_sc_b = 0; e_fc_b = 0;
    end else if (b) begin
      if (ctl[7] && e_sc_b < 15) e_sc_b++;
      if (ctl[2] && e_fc_b < 15) e_fc_b++;
    end else begin
      if (ctl[7]) e_sc_a++;
      if (ctl[2]) e_fc_a++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_id_rs = '0; a_ex_rs = '0; a_id_used = '0; a_ex_rd = '0; a_mem_rd = '0; a_wb_rd = '0;
    a_ex_we = 0; a_ex_mr = 0; a_mc = 0; a_br = 0; a_mem_we = 0; a_wb_we = 0;
    b_id_rs = '0; b_ex_rs = '0; b_id_used = '0; b_ex_rd = '0; b_mem_rd = '0; b_wb_rd = '0;
    b_ex_we = 0; b_ex_mr = 0; b_mc = 0; b_br = 0; b_mem_we = 0; b_wb_we = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_dut = dut_q.pop_front();
      m_name = name_q.pop_front();
      m_obs = obs(m_dut);
      checks++;
      if (m_obs !== m_exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h (fwd|ctl|stall|flush)", m_name, m_obs, m_exp);
      end
    end
  end

  always @(negedge clk) begin
    assert (rst || !(a_br && a_mc)) else $error("illegal stimulus: branch_taken with ex_mc_start on dut_a");
    assert (rst || !(b_br && b_mc)) else $error("illegal stimulus: branch_taken with ex_mc_start on dut_b");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    a_ex_rs = {5'd0, 5'd5}; a_mem_rd = 5'd5; a_mem_we = 1; a_br = 1; a_mc = 0;
    cyc(0, "reset_forced", 6'b0, NONE);
    rst = 1'b0;
    clear_inputs();
    a_ex_rs = {5'd0, 5'd5}; a_mem_rd = 5'd5; a_mem_we = 1; a_wb_rd = 5'd5; a_wb_we = 1;
    cyc(0, "fwd_mem", 6'b000010, NONE);
    a_mem_we = 0;
    cyc(0, "fwd_wb", 6'b000001, NONE);
    a_ex_rs = '0; a_mem_rd = '0; a_wb_rd = '0; a_mem_we = 1;
    cyc(0, "fwd_x0", 6'b000000, NONE);
    a_ex_rs = {5'd3, 5'd3}; a_mem_rd = 5'd3; a_wb_rd = 5'd3;
    cyc(0, "fwd_both_mem", 6'b001010, NONE);
    a_ex_rs = {5'd9, 5'd3}; a_wb_rd = 5'd9;
    cyc(0, "fwd_mixed", 6'b000110, NONE);
    clear_inputs();
    a_ex_mr = 1; a_ex_we = 1; a_ex_rd = 5'd7; a_id_rs = {5'd7, 5'd2}; a_id_used = 2'b10;
    cyc(0, "lu_op1", 6'b0, STALL);
    a_id_used = 2'b01;
    cyc(0, "lu_unused", 6'b0, NONE);
    a_ex_rd = 5'd0; a_id_rs = {5'd0, 5'd2}; a_id_used = 2'b11;
    cyc(0, "lu_x0", 6'b0, NONE);
    a_ex_rd = 5'd7; a_id_rs = {5'd7, 5'd2}; a_br = 1;
    cyc(0, "lu_branch", 6'b0, FLUSH);
    a_ex_mr = 0;
    cyc(0, "branch", 6'b0, FLUSH);
    clear_inputs();
    cyc(0, "idle_counts", 6'b0, NONE);
    a_mc = 1;
    cyc(0, "mc1_start", 6'b0, HOLD);
    a_ex_mr = 1; a_ex_rd = 5'd7; a_id_rs = {5'd7, 5'd2}; a_id_used = 2'b11;
    cyc(0, "mc1_busy_lu_masked", 6'b0, HOLD);
    cyc(0, "mc1_busy2", 6'b0, HOLD);
    cyc(0, "mc1_done", 6'b0, DONE);
    a_ex_mr = 0; a_id_used = 2'b00;
    cyc(0, "mc2_start", 6'b0, HOLD);
    cyc(0, "mc2_busy1", 6'b0, HOLD);
    cyc(0, "mc2_busy2", 6'b0, HOLD);
    cyc(0, "mc2_done", 6'b0, DONE);
    a_mc = 0;
    cyc(0, "mc_after", 6'b0, NONE);
    a_mc = 1;
    cyc(0, "rst_mc_start", 6'b0, HOLD);
    rst = 1'b1;
    cyc(0, "rst_in_busy", 6'b0, NONE);
    rst = 1'b0; a_mc = 0;
    cyc(0, "rst_back_run", 6'b0, NONE);
    a_mc = 1;
    cyc(0, "mc3_start", 6'b0, HOLD);
    cyc(0, "mc3_busy1", 6'b0, HOLD);
    cyc(0, "mc3_busy2", 6'b0, HOLD);
    cyc(0, "mc3_done", 6'b0, DONE);
    a_mc = 0;
    cyc(0, "mc3_after", 6'b0, NONE);
    clear_inputs();
    b_ex_mr = 1; b_ex_we = 1; b_ex_rd = 5'd7; b_id_rs = {5'd7, 5'd1, 5'd2}; b_id_used = 3'b100;
    b_ex_rs = {5'd4, 5'd0, 5'd0}; b_mem_rd = 5'd4; b_mem_we = 1;
    cyc(1, "b_lu_op2_fwd_mem", 6'b100000, STALL);
    b_ex_rs = {5'd6, 5'd0, 5'd0}; b_wb_rd = 5'd6; b_wb_we = 1;
    cyc(1, "b_lu_op2_fwd_wb", 6'b010000, STALL);
    b_id_used = 3'b011;
    cyc(1, "b_lu_unused", 6'b010000, NONE);
    b_id_used = 3'b100;
    for (int i = 0; i < 20; i++) cyc(1, $sformatf("b_sat_%0d", i), 6'b010000, STALL);
    clear_inputs();
    b_mc = 1;
    cyc(1, "b_mc_start", 6'b0, HOLD);
    cyc(1, "b_mc_done", 6'b0, DONE);
    b_mc = 0;
    cyc(1, "b_sat_end", 6'b0, NONE);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised hazard controller for the in-order RV32 pipeline (IF/ID/EX/MEM/WB), replacing the pure-combinational forwarding unit. Produces per-operand forwarding selects for `NSRC` source operands, detects load-use hazards, freezes the pipeline for multi-cycle EX operations (`MC_LAT` cycles), flushes on taken branches, and keeps saturating stall and flush performance counters. Sits beside the pipeline registers and drives their enable, flush and bubble controls.

## Interface

Parameters:
- `AW`, 5, register address width
- `NSRC`, 2, source operands per instruction (3 for fused/R4 ops)
- `MC_LAT`, 4, EX occupancy of a multi-cycle op in cycles; must be ≥2
- `CNT_W`, 32, performance counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_rs`  in  NSRC*AW  IF/ID source addresses; operand k at bits [k*AW +: AW]
- `id_rs_used`  in  NSRC  operand k is actually read by the ID instruction
- `ex_rs`  in  NSRC*AW  ID/EX source addresses
- `ex_rd`, `ex_reg_write_en`, `ex_mem_read`  in  AW/1/1  ID/EX destination, write enable, load flag
- `ex_mc_start`  in  1  ID/EX holds a multi-cycle op
- `branch_taken`  in  1  branch/jump resolved taken in EX
- `mem_rd`, `mem_reg_write_en`  in  AW/1  EX/MEM destination and write enable
- `wb_rd`, `wb_reg_write_en`  in  AW/1  MEM/WB destination and write enable
- `forward_sel`  out  2*NSRC  per-operand select; operand k at bits [2k +: 2]
- `pc_hold`, `ifid_hold`, `idex_hold`  out  1 each  hold the register (write enable low)
- `idex_bubble`, `exmem_bubble`  out  1 each  load a NOP into the register
- `ifid_flush`, `idex_flush`  out  1 each  clear the register
- `mc_done`  out  1  the multi-cycle result is valid in EX this cycle
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters

## Operation

- Forwarding, per operand k, combinational:
  - `10` if `mem_reg_write_en`, `mem_rd`≠0 and `mem_rd`==`ex_rs[k]`.
  - Otherwise `01` if `wb_reg_write_en`, `wb_rd`≠0 and `wb_rd`==`ex_rs[k]`.
  - Otherwise `00`.
  - EX/MEM takes priority over MEM/WB.
- Load-use hazard: `ex_mem_read` && `ex_rd`≠0 && any k with `id_rs_used[k]` and `id_rs[k]`==`ex_rd`. Response is `pc_hold`, `ifid_hold` and `idex_bubble` for one cycle.
- Taken branch: `ifid_flush` and `idex_flush` assert in the same cycle. This has priority over the load-use stall; the stall is suppressed because the ID instruction is wrong-path.
- FSM states are RUN and BUSY, with down-counter `mc_cnt` (width clog2(MC_LAT)).
  - RUN with `ex_mc_start`: assert `pc_hold`, `ifid_hold`, `idex_hold`, `exmem_bubble`. Load `mc_cnt`=MC_LAT-2 and go to BUSY.
  - BUSY with `mc_cnt`≠0: same four outputs asserted; decrement `mc_cnt`.
  - BUSY with `mc_cnt`==0: no hold. Assert `mc_done` and return to RUN.
  - `ex_mc_start` is ignored in BUSY, because the held op keeps asserting it.
- During BUSY, load-use detection and `branch_taken` are masked. `branch_taken` together with `ex_mc_start` is illegal; the bench asserts it never occurs.
- The multi-cycle unit latches operands in its start cycle, so forwarding changes while the older instructions drain are harmless.
- `stall_cnt` increments every cycle `pc_hold` is high. `flush_cnt` increments every cycle `ifid_flush` is high. Both saturate at all-ones.

## Timing

- Forwarding, hazard, flush, hold and bubble outputs are combinational from the current inputs and state, with zero latency.
- A multi-cycle op occupies EX for exactly MC_LAT cycles; the front end is held for MC_LAT-1 of them.
- Reset values: state RUN, `mc_cnt`=0, both counters 0.
- While `rst` is high, every hold/flush/bubble output, `mc_done` and `forward_sel` are forced to 0.
- Reset in BUSY aborts the op; the next cycle after `rst` falls is RUN.
- Back-to-back multi-cycle ops: release cycle, then a new start on the next cycle.

## Structure

- Package `hazard_pkg` holds:
  - `FWD_NONE`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10
  - state encodings `ST_RUN`, `ST_BUSY`
- Sub-module `fwd_select` computes one operand's select. It is instantiated NSRC times in a generate loop.
- The FSM, the counters and the hazard logic stay in the top module.

## Test plan

- `ex_rs[0]`=5, `mem_rd`=5 and `wb_rd`=5, both write enables high → `forward_sel[1:0]`=10. Repeat with `mem_reg_write_en`=0 → 01. Repeat with rd=0 → 00.
- Load to x7 in EX; ID uses x7 on operand 1 with `id_rs_used[1]`=1 → `pc_hold`, `ifid_hold`, `idex_bubble` high for one cycle. Same case with `id_rs_used[1]`=0 → no stall.
- Load-use hazard and `branch_taken` in the same cycle → both flushes high, no hold, `stall_cnt` unchanged, `flush_cnt` +1.
- MC_LAT=4, `ex_mc_start` held high → holds for 3 cycles, `mc_done` on the 4th, `stall_cnt`=3. A second op starts immediately after and repeats the pattern.
- `rst` pulsed on the 2nd BUSY cycle → next cycle RUN, all outputs 0, counters 0.
- CNT_W=4, 20 stall cycles → `stall_cnt` stops at 15.
- NSRC=3, hazard only on operand 2 → detected; `forward_sel[5:4]` correct.
